// File: rtl/fifo_rd_stream.sv
// Read-domain output stage: issues FIFO reads under a 2-word credit rule and
// presents the data as a registered first-word-fall-through valid/ready stream.
`timescale 1ns/1ps
module fifo_rd_stream #(
  parameter int WIDTH = 4
) (
  input  logic             r_clk,
  input  logic             rst,
  input  logic             empty,
  output logic             rd_rq,
  input  logic [WIDTH-1:0] rdata,
  input  logic             flush,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic [1:0]       level
);

  logic [WIDTH-1:0] skid;
  logic             inflight;
  logic             pop;
  logic             arrive;
  logic             credit;
  logic [1:0]       level_nxt;

  assign pop       = m_valid & m_ready;
  assign arrive    = inflight & ~flush;
  // held + in-flight words never exceed the two buffer slots; a same-cycle
  // pop frees a slot, which keeps the stream at one word per cycle
  assign credit    = (level + {1'b0, inflight}) < 2'd2;
  assign rd_rq     = ~rst & ~flush & ~empty & (credit | pop);
  assign level_nxt = level + {1'b0, arrive} - {1'b0, pop};

  always_ff @(posedge r_clk) begin
    if (rst) begin
      level    <= 2'd0;
      inflight <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      skid     <= '0;
    end else if (flush) begin
      level    <= 2'd0;
      inflight <= 1'b0;
      m_valid  <= 1'b0;
    end else begin
      level    <= level_nxt;
      inflight <= rd_rq;
      m_valid  <= (level_nxt != 2'd0);
      // head always holds the oldest word; skid only fills behind it
      case (level)
        2'd0: if (arrive) m_data <= rdata;
        2'd1: if (arrive) begin
          if (pop) m_data <= rdata;
          else     skid   <= rdata;
        end
        2'd2: if (pop) begin
          m_data <= skid;
          if (arrive) skid <= rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scenario bench for fifo_rd_stream against a queue-based FIFO/buffer model.
`timescale 1ns/1ps
module tb_fifo_rd_stream;
  logic       r_clk = 1'b0;
  logic       rst, empty, rd_rq, flush, m_valid, m_ready;
  logic [3:0] rdata, m_data;
  logic [1:0] level;

  fifo_rd_stream #(.WIDTH(4)) dut (
    .r_clk(r_clk), .rst(rst), .empty(empty), .rd_rq(rd_rq), .rdata(rdata),
    .flush(flush), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .level(level)
  );

  always #5 r_clk = ~r_clk;

  int checks = 0;
  int errors = 0;

  // model: words still in FIFO memory, words in the output buffer, word on the read bus
  int fifo_q[$];
  int buf_q[$];
  int got_q[$];
  bit pend;
  int pend_w;
  bit exp_rq;
  bit stall;
  int ev, el, ed;

  task automatic drive(input bit r, input bit f, input bit mr);
    rst     = r;
    flush   = f;
    m_ready = mr;
    empty   = stall || (fifo_q.size() == 0);
    rdata   = pend ? 4'(pend_w) : 4'($urandom);
    exp_rq  = !r && !f && !empty &&
              ((buf_q.size() + int'(pend) < 2) || (mr && buf_q.size() > 0));
    #1;
  endtask

  task automatic advance();
    @(posedge r_clk);
    if (!rst && m_ready && buf_q.size() > 0) got_q.push_back(buf_q.pop_front());
    if (rst || flush) begin
      buf_q.delete();
      pend = 1'b0;
    end else begin
      if (pend) buf_q.push_back(pend_w);
      pend = exp_rq;
      if (exp_rq) pend_w = fifo_q.pop_front();
    end
    @(negedge r_clk);
    el = buf_q.size();
    ev = (el != 0);
    ed = ev ? buf_q[0] : 0;
  endtask

  function automatic bit seq_ok(input int first, input int n);
    if (got_q.size() != n) return 1'b0;
    for (int k = 0; k < n; k++) if (got_q[k] != first + k) return 1'b0;
    return 1'b1;
  endfunction

  task automatic load(input int first, input int n);
    fifo_q.delete();
    got_q.delete();
    for (int k = 0; k < n; k++) fifo_q.push_back(first + k);
  endtask

  task automatic test_reset();
    load(1, 3);
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 1);
      checks++; if (rd_rq !== 1'b0) begin errors++; $display("FAIL reset_rq cyc %0d: got %b need 0", i, rd_rq); end
      advance();
      checks++;
      if (m_valid !== 1'b0 || level !== 2'd0 || m_data !== 4'h0) begin
        errors++; $display("FAIL reset_out cyc %0d: got v%b l%0d d%h need v0 l0 d0", i, m_valid, level, m_data);
      end
    end
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1);
      if (i == 0) begin
        checks++; if (rd_rq !== 1'b1) begin errors++; $display("FAIL reset_first_rq: got %b need 1", rd_rq); end
      end
      checks++; if (rd_rq !== exp_rq) begin errors++; $display("FAIL reset_rq2 cyc %0d: got %b need %b", i, rd_rq, exp_rq); end
      advance();
    end
    checks++; if (!seq_ok(1, 3)) begin errors++; $display("FAIL reset_drain: got %0d words need 1..3", got_q.size()); end
  endtask

  task automatic test_single();
    load(4'hA, 1);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, i == 2);
      checks++; if (rd_rq !== exp_rq) begin errors++; $display("FAIL single_rq cyc %0d: got %b need %b", i, rd_rq, exp_rq); end
      advance();
      checks++;
      if (m_valid !== 1'(ev) || level !== 2'(el) || (ev != 0 && m_data !== 4'(ed))) begin
        errors++; $display("FAIL single_out cyc %0d: got v%b l%0d d%h need v%0d l%0d d%h", i, m_valid, level, m_data, ev, el, ed);
      end
      if (i == 1) begin
        checks++; if (m_valid !== 1'b1 || m_data !== 4'hA) begin errors++; $display("FAIL single_word: got v%b d%h need v1 dA", m_valid, m_data); end
      end
    end
    checks++; if (m_valid !== 1'b0 || level !== 2'd0) begin errors++; $display("FAIL single_pop: got v%b l%0d need v0 l0", m_valid, level); end
  endtask

  task automatic test_streaming();
    int rq_n = 0, rq_first = -1, rq_last = -1, pop_first = -1, pop_last = -1;
    load(1, 8);
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 1);
      if (rd_rq) begin rq_n++; if (rq_first < 0) rq_first = i; rq_last = i; end
      if (m_valid) begin if (pop_first < 0) pop_first = i; pop_last = i; end
      checks++; if (rd_rq !== exp_rq) begin errors++; $display("FAIL stream_rq cyc %0d: got %b need %b", i, rd_rq, exp_rq); end
      advance();
      checks++;
      if (m_valid !== 1'(ev) || level !== 2'(el) || (ev != 0 && m_data !== 4'(ed))) begin
        errors++; $display("FAIL stream_out cyc %0d: got v%b l%0d d%h need v%0d l%0d d%h", i, m_valid, level, m_data, ev, el, ed);
      end
    end
    checks++; if (rq_n != 8 || rq_first != 0 || rq_last != 7) begin errors++; $display("FAIL stream_rq_run: got n%0d %0d..%0d need n8 0..7", rq_n, rq_first, rq_last); end
    checks++; if (pop_first != 2 || pop_last != 9) begin errors++; $display("FAIL stream_pop_run: got %0d..%0d need 2..9", pop_first, pop_last); end
    checks++; if (!seq_ok(1, 8)) begin errors++; $display("FAIL stream_order: got %0d words need 1..8", got_q.size()); end
  endtask

  task automatic test_backpressure();
    int rq_n = 0, pop_n = 0, pop_last = -1;
    load(1, 5);
    for (int i = 0; i < 14; i++) begin
      drive(0, 0, i >= 6);
      if (i < 6 && rd_rq) rq_n++;
      if (i >= 6 && m_valid) begin pop_n++; pop_last = i; end
      checks++; if (rd_rq !== exp_rq) begin errors++; $display("FAIL bp_rq cyc %0d: got %b need %b", i, rd_rq, exp_rq); end
      advance();
      checks++;
      if (m_valid !== 1'(ev) || level !== 2'(el) || (ev != 0 && m_data !== 4'(ed))) begin
        errors++; $display("FAIL bp_out cyc %0d: got v%b l%0d d%h need v%0d l%0d d%h", i, m_valid, level, m_data, ev, el, ed);
      end
      if (i == 5) begin
        checks++;
        if (rq_n != 2 || level !== 2'd2 || m_data !== 4'h1) begin
          errors++; $display("FAIL bp_hold: got reads%0d l%0d d%h need reads2 l2 d1", rq_n, level, m_data);
        end
      end
    end
    checks++; if (pop_n != 5 || pop_last != 10) begin errors++; $display("FAIL bp_gapless: got %0d pops last %0d need 5 last 10", pop_n, pop_last); end
    checks++; if (!seq_ok(1, 5)) begin errors++; $display("FAIL bp_order: got %0d words need 1..5", got_q.size()); end
  endtask

  task automatic test_flush();
    load(3, 4);
    for (int i = 0; i < 9; i++) begin
      drive(0, i == 2, i >= 3);
      checks++; if (rd_rq !== exp_rq) begin errors++; $display("FAIL flush_rq cyc %0d: got %b need %b", i, rd_rq, exp_rq); end
      advance();
      checks++;
      if (m_valid !== 1'(ev) || level !== 2'(el) || (ev != 0 && m_data !== 4'(ed))) begin
        errors++; $display("FAIL flush_out cyc %0d: got v%b l%0d d%h need v%0d l%0d d%h", i, m_valid, level, m_data, ev, el, ed);
      end
      if (i == 1) begin
        checks++; if (level !== 2'd1 || m_data !== 4'h3 || dut.inflight !== 1'b1) begin errors++; $display("FAIL flush_setup: got l%0d d%h inf%b need l1 d3 inf1", level, m_data, dut.inflight); end
      end
      if (i == 2) begin
        checks++; if (level !== 2'd0 || m_valid !== 1'b0) begin errors++; $display("FAIL flush_clear: got l%0d v%b need l0 v0", level, m_valid); end
      end
    end
    checks++; if (!seq_ok(5, 2)) begin errors++; $display("FAIL flush_next: got %0d words first %0d need 5,6", got_q.size(), got_q.size() ? got_q[0] : -1); end
  endtask

  task automatic test_reset_midstream();
    load(1, 6);
    for (int i = 0; i < 13; i++) begin
      drive(i == 4, 0, i >= 5);
      checks++; if (rd_rq !== exp_rq) begin errors++; $display("FAIL rstmid_rq cyc %0d: got %b need %b", i, rd_rq, exp_rq); end
      if (i == 4) begin
        checks++; if (level !== 2'd2) begin errors++; $display("FAIL rstmid_pre: got l%0d need l2", level); end
      end
      advance();
      checks++;
      if (m_valid !== 1'(ev) || level !== 2'(el) || (ev != 0 && m_data !== 4'(ed))) begin
        errors++; $display("FAIL rstmid_out cyc %0d: got v%b l%0d d%h need v%0d l%0d d%h", i, m_valid, level, m_data, ev, el, ed);
      end
      if (i == 4) begin
        checks++; if (m_valid !== 1'b0 || level !== 2'd0) begin errors++; $display("FAIL rstmid_clear: got v%b l%0d need v0 l0", m_valid, level); end
      end
    end
    checks++; if (!seq_ok(3, 4)) begin errors++; $display("FAIL rstmid_resume: got %0d words first %0d need 3..6", got_q.size(), got_q.size() ? got_q[0] : -1); end
  endtask

  task automatic test_random();
    int next_w = 0;
    fifo_q.delete();
    got_q.delete();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 1 && fifo_q.size() < 16) begin fifo_q.push_back(next_w % 16); next_w++; end
      stall = ($urandom_range(0, 4) == 0);
      drive(0, $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 6);
      checks++; if (rd_rq !== exp_rq) begin errors++; $display("FAIL rand_rq cyc %0d: got %b need %b", i, rd_rq, exp_rq); end
      advance();
      checks++;
      if (m_valid !== 1'(ev) || level !== 2'(el) || (ev != 0 && m_data !== 4'(ed))) begin
        errors++; $display("FAIL rand_out cyc %0d: got v%b l%0d d%h need v%0d l%0d d%h", i, m_valid, level, m_data, ev, el, ed);
      end
      checks++;
      if (int'(level) + int'(dut.inflight) > 2) begin
        errors++; $display("FAIL rand_credit cyc %0d: got l%0d inf%b need sum<=2", i, level, dut.inflight);
      end
    end
    stall = 1'b0;
  endtask

  initial begin
    pend  = 1'b0;
    stall = 1'b0;
    test_reset();
    test_single();
    test_streaming();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-domain output stage of the asynchronous FIFO. It sits directly downstream of the read-pointer/empty block. It drives that block's `rd_rq`, captures the memory read data and presents it as a registered valid/ready stream through a 2-entry output buffer. The consumer sees first-word-fall-through data at full throughput without any combinational path from `empty` or `rdata` to its outputs.

## Interface
- `WIDTH`, 4, data word width; matches FIFO memory width.
- `r_clk`  in  1  read-domain clock; all state on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `empty`  in  1  FIFO empty flag from the read-pointer block, registered in `r_clk` domain.
- `rd_rq`  out  1  read request to the read-pointer block; a read is accepted in any cycle with `rd_rq=1`.
- `rdata`  in  WIDTH  FIFO memory read data; valid in the cycle after an accepted read.
- `flush`  in  1  discard all buffered and in-flight words; FIFO pointers unaffected.
- `m_valid`  out  1  output word available.
- `m_data`  out  WIDTH  output word (buffer head).
- `m_ready`  in  1  consumer accepts `m_data` when `m_valid & m_ready`.
- `level`  out  2  words currently held in the buffer, range 0..2.

## Operation
- Storage: head register (drives `m_data`), skid register, `level` (states L0/L1/L2), `inflight` flag (read issued last cycle).
- `pop = m_valid & m_ready`.
- `arrive = inflight & ~flush`.
- `rd_rq = ~rst & ~flush & ~empty & ((level + inflight < 2) | pop)`.
  - The combinational path `m_ready` -> `rd_rq` is intentional; it gives full throughput.
  - `rd_rq` never asserts while `empty=1`, so every request is accepted.
- `inflight` next = `rd_rq`.
- `level` next = `level + arrive - pop`, except on `flush` (see below).
- Invariant: `level + inflight <= 2` at every edge; the bench asserts it.
- Data movement, by (level, pop, arrive):
  - L0, arrive: head <= rdata.
  - L1, no pop, arrive: skid <= rdata.
  - L1, pop, arrive: head <= rdata.
  - L2, pop: head <= skid.
  - L2, pop, arrive: head <= skid, skid <= rdata.
  - L2, no pop, arrive: illegal, unreachable by credit rule.
- `m_valid = (level != 0)`, registered. Words leave in FIFO order; none is lost or duplicated.
- Flush, when `flush=1` in a cycle:
  - A `pop` in that same cycle is a valid transfer.
  - All other held words and the word arriving that cycle are discarded.
  - `level` <= 0, `inflight` <= 0, `rd_rq` = 0 that cycle.
  - Issuing resumes the next cycle.
- Reset (`rst=1` at an edge):
  - `level=0`, `inflight=0`, `m_valid=0`, head=0, skid=0.
  - `rd_rq=0` combinationally while `rst=1`.
  - Reset asserted mid-operation discards any in-flight word.

## Timing
- Read accepted at edge T: `rdata` is valid during T+1 and captured at the end of T+1. With the buffer otherwise empty, `m_valid=1` from T+2.
- Latency from `empty` falling to first `m_valid`: 2 cycles, with the consumer idle and the buffer empty.
- Steady state with `m_ready=1` and FIFO non-empty: one word per cycle on `m_valid`; `rd_rq` held high.
- With `m_ready=0`: at most 2 reads issue after the buffer drains; then `rd_rq=0` and `level=2` until a pop.
- `m_valid`, `m_data` and `level` are register outputs. `rd_rq` is combinational from `rst`, `flush`, `empty`, `m_ready` and state.
- `m_data` is stable while `m_valid=1 & m_ready=0`.

## Test plan
- Reset: `rst=1` for 2 cycles with `empty=0` and `m_ready=1` -> `rd_rq=0`, `m_valid=0`, `level=0` throughout; first `rd_rq=1` in the cycle after `rst` falls.
- Single word: `empty=0` for one accepted read, `rdata=4'hA` the next cycle -> `m_valid=1`, `m_data=4'hA` two cycles after the read; pop with `m_ready=1` -> `level=0`, `m_valid=0`.
- Streaming: FIFO model holds 1..8, `m_ready=1` -> `rd_rq` high 8 consecutive cycles; `m_data` = 1..8 on 8 consecutive cycles starting 2 cycles after the first read; `empty` then stops requests.
- Backpressure: FIFO holds 1..5, `m_ready=0` -> exactly 2 reads, `level=2`, `m_data=1`; then `m_ready=1` -> 1..5 delivered in order with no gaps after resume and no loss.
- Flush with in-flight data: `level=1` (word 3), `inflight=1` (word 4), `flush=1` with `m_ready=0` -> next cycle `level=0`, `m_valid=0`; word 4 dropped; next word delivered is 5.
- Reset mid-stream: assert `rst` while `level=2` and FIFO non-empty -> next cycle `m_valid=0`, `level=0`; after release, streaming resumes from the FIFO's current head.
